// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the reorder buffer.
// Each ROB head entry gets exactly one action: a register-file write, a store
// to data memory with a req/ack handshake, or a precise exception (flush,
// EPC capture and redirect to the exception vector).
module commit_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             rob_valid,
    input  logic [31:0]      rob_val,
    input  logic [4:0]       rob_rd,
    input  logic             rob_store,
    input  logic [31:0]      rob_addr,
    input  logic             rob_ex,
    input  logic [31:0]      rob_pc,
    output logic             rob_pop,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             flush,
    output logic [31:0]      epc,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t state, state_nxt;

    // One-hot action strobes for the current cycle.
    logic take_ex;   // excepting entry accepted
    logic take_st;   // store entry accepted, handshake starts next cycle
    logic take_wr;   // register-write entry retired
    logic st_done;   // store acknowledged, entry retired

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state, action decode and the combinational ROB pop.
    always_comb begin
        state_nxt = state;
        take_ex   = 1'b0;
        take_st   = 1'b0;
        take_wr   = 1'b0;
        st_done   = 1'b0;
        rob_pop   = 1'b0;
        case (state)
            RUN: begin
                if (rob_valid && !stall) begin
                    if (rob_ex) begin
                        take_ex   = 1'b1;
                        rob_pop   = 1'b1;
                        state_nxt = FLUSH;
                    end else if (rob_store) begin
                        // Store is popped only once memory accepts it.
                        take_st   = 1'b1;
                        state_nxt = STORE_WAIT;
                    end else begin
                        take_wr   = 1'b1;
                        rob_pop   = 1'b1;
                    end
                end
            end
            STORE_WAIT: begin
                // Not abortable: stall has no effect here.
                if (mem_ack) begin
                    st_done   = 1'b1;
                    rob_pop   = 1'b1;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // ROB inputs ignored for the flush cycle.
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // Nothing is consumed while held in reset.
        if (!rst_n) rob_pop = 1'b0;
    end

    // Register-file write port: single-cycle pulse, r0 writes suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= take_wr && (rob_rd != 5'd0);
            if (take_wr) begin
                rf_waddr <= rob_rd;
                rf_wdata <= rob_val;
            end
        end
    end

    // Store request: address/data captured at acceptance and held until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (take_st) begin
            mem_req   <= 1'b1;
            mem_addr  <= rob_addr;
            mem_wdata <= rob_val;
        end else if (st_done) begin
            mem_req   <= 1'b0;
        end
    end

    // Exception capture: flush pulse coincides with the FLUSH state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            epc         <= 32'd0;
            redirect_pc <= 32'd0;
        end else begin
            flush <= take_ex;
            if (take_ex) begin
                epc         <= rob_pc;
                redirect_pc <= EXC_VECTOR;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 retired <= '0;
        else if (take_wr || st_done) retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: reset, ALU/r0 retirement, store handshake,
// exception flush, stall and counter wrap (second instance with CNT_W=4).
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        rob_valid;
    logic [31:0] rob_val;
    logic [4:0]  rob_rd;
    logic        rob_store;
    logic [31:0] rob_addr;
    logic        rob_ex;
    logic [31:0] rob_pc;
    logic        mem_ack;

    logic        rob_pop, rf_we, mem_req, flush;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, mem_addr, mem_wdata, epc, redirect_pc;
    logic [31:0] retired;

    logic        pop4, we4, req4, flush4;
    logic [4:0]  waddr4;
    logic [31:0] wdata4, maddr4, mwdata4, epc4, rpc4;
    logic [3:0]  retired4;

    int npass = 0;
    int ntotal = 0;

    commit_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .rob_valid(rob_valid), .rob_val(rob_val), .rob_rd(rob_rd),
        .rob_store(rob_store), .rob_addr(rob_addr), .rob_ex(rob_ex), .rob_pc(rob_pc),
        .rob_pop(rob_pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .flush(flush), .epc(epc), .redirect_pc(redirect_pc), .retired(retired)
    );

    commit_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .rob_valid(rob_valid), .rob_val(rob_val), .rob_rd(rob_rd),
        .rob_store(rob_store), .rob_addr(rob_addr), .rob_ex(rob_ex), .rob_pc(rob_pc),
        .rob_pop(pop4), .rf_we(we4), .rf_waddr(waddr4), .rf_wdata(wdata4),
        .mem_req(req4), .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_ack(mem_ack),
        .flush(flush4), .epc(epc4), .redirect_pc(rpc4), .retired(retired4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rob_valid = 1'b0; rob_store = 1'b0; rob_ex = 1'b0;
        rob_rd = 5'd0; rob_val = 32'd0; rob_addr = 32'd0; rob_pc = 32'd0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] val);
        rob_valid = 1'b1; rob_store = 1'b0; rob_ex = 1'b0;
        rob_rd = rd; rob_val = val;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; mem_ack = 1'b0;
        idle();
        tick(); tick();
        // Reset state.
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_flush", flush, 0);
        chk("rst_epc", epc, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_retired", retired, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a store.
        rob_valid = 1'b1; rob_store = 1'b1; rob_addr = 32'h100; rob_val = 32'hAB;
        #1 chk("st0_pop", rob_pop, 0);
        tick();
        chk("st0_req", mem_req, 1);
        chk("st0_addr", mem_addr, 32'h100);
        alu(5'd2, 32'h99);
        #2 rst_n = 1'b0;
        #1 chk("st0_rst_req", mem_req, 0);
        chk("st0_rst_pop", rob_pop, 0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        chk("st0_after_retired", retired, 0);
        chk("st0_after_req", mem_req, 0);
        chk("st0_after_we", rf_we, 0);

        // ALU writes with an r0 entry in the middle.
        alu(5'd5, 32'h11);
        #1 chk("alu1_pop", rob_pop, 1);
        tick();
        chk("alu1_we", rf_we, 1);
        chk("alu1_waddr", rf_waddr, 5);
        chk("alu1_wdata", rf_wdata, 32'h11);
        alu(5'd0, 32'h22);
        #1 chk("alu2_pop", rob_pop, 1);
        tick();
        chk("alu2_we", rf_we, 0);
        alu(5'd7, 32'h33);
        #1 chk("alu3_pop", rob_pop, 1);
        tick();
        idle();
        chk("alu3_we", rf_we, 1);
        chk("alu3_waddr", rf_waddr, 7);
        chk("alu3_wdata", rf_wdata, 32'h33);
        chk("alu_retired", retired, 3);
        tick();
        chk("alu_we_pulse", rf_we, 0);

        // mem_ack with no outstanding request does nothing.
        mem_ack = 1'b1;
        #1 chk("stray_ack_pop", rob_pop, 0);
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_retired", retired, 3);

        // Store handshake, with stall asserted during the wait.
        rob_valid = 1'b1; rob_store = 1'b1; rob_addr = 32'h2000; rob_val = 32'hDEADBEEF;
        #1 chk("st_accept_pop", rob_pop, 0);
        tick();
        rob_addr = 32'h5555; rob_val = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            stall = (i >= 2);
            chk("st_wait_req", mem_req, 1);
            chk("st_wait_addr", mem_addr, 32'h2000);
            chk("st_wait_data", mem_wdata, 32'hDEADBEEF);
            #1 chk("st_wait_pop", rob_pop, 0);
            tick();
        end
        mem_ack = 1'b1;
        #1 chk("st_ack_pop", rob_pop, 1);
        tick();
        mem_ack = 1'b0; stall = 1'b0;
        idle();
        chk("st_done_req", mem_req, 0);
        chk("st_retired", retired, 4);
        #1 chk("st_done_pop", rob_pop, 0);
        tick();

        // Exception followed immediately by a valid entry.
        rob_valid = 1'b1; rob_ex = 1'b1; rob_pc = 32'h0040_0010; rob_rd = 5'd4;
        #1 chk("ex_pop", rob_pop, 1);
        tick();
        chk("ex_flush", flush, 1);
        chk("ex_epc", epc, 32'h0040_0010);
        chk("ex_redirect", redirect_pc, 32'h180);
        chk("ex_we", rf_we, 0);
        chk("ex_retired", retired, 4);
        alu(5'd3, 32'h55);
        #1 chk("flush_pop", rob_pop, 0);
        tick();
        chk("flush_end", flush, 0);
        chk("flush_we", rf_we, 0);
        chk("flush_epc_hold", epc, 32'h0040_0010);
        #1 chk("post_flush_pop", rob_pop, 1);
        tick();
        idle();
        chk("post_flush_we", rf_we, 1);
        chk("post_flush_waddr", rf_waddr, 3);
        chk("post_flush_retired", retired, 5);

        // Stall in RUN blocks retirement.
        stall = 1'b1;
        alu(5'd9, 32'h77);
        #1 chk("stall_pop", rob_pop, 0);
        tick();
        chk("stall_we", rf_we, 0);
        chk("stall_retired", retired, 5);
        stall = 1'b0;
        idle();
        tick();

        // Counter wrap on the 4-bit instance.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        alu(5'd1, 32'h1);
        repeat (17) tick();
        idle();
        chk("wrap_retired4", retired4, 1);
        chk("wrap_retired32", retired, 17);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
